// File: rtl/cont_delay_line.sv
// Clocked model of a delayed net: din is the driven value and dout follows it
// D = ASSIGN_DLY + NET_DLY cycles later.
// MODE 0 (inertial): one pending update. A newer change replaces it, and a
// return to the current dout cancels it.
// MODE 1 (transport): every change is queued with its due time and
// replayed in order.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : driven value, sampled each rising edge
//   clr_ovf    : synchronous clear of ovf
//   dout       : delayed net value
//   pending    : at least one scheduled update is outstanding
//   cancel     : one-cycle pulse when an inertial pending update is discarded
//   ovf        : sticky, set when a transport event is dropped on a full queue
module cont_delay_line #(
    parameter int               WIDTH      = 1,
    parameter int               ASSIGN_DLY = 1,
    parameter int               NET_DLY    = 1,
    parameter int               MODE       = 0,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] dout,
    output logic             pending,
    output logic             cancel,
    output logic             ovf
);

    localparam int          DLY_SUM   = ASSIGN_DLY + NET_DLY;
    localparam int unsigned D         = (DLY_SUM < 1) ? 32'd1 : 32'(DLY_SUM);
    localparam int unsigned DEP       = (DEPTH < 1) ? 32'd1 : 32'(DEPTH);
    localparam int unsigned CW        = $clog2(D + 1);
    localparam int unsigned TW        = $clog2(D) + 1;
    localparam int unsigned PW        = (DEP > 1) ? $clog2(DEP) : 1;
    localparam int unsigned NW        = $clog2(DEP + 1);
    localparam bit          TRANSPORT = (MODE == 1);

    // Reject illegal configurations at elaboration.
    if (DLY_SUM < 1 || DEPTH < 1 || (MODE != 0 && MODE != 1)) begin : g_param_check
        $error("cont_delay_line: illegal parameters D=%0d DEPTH=%0d MODE=%0d",
               DLY_SUM, DEPTH, MODE);
    end

    logic [WIDTH-1:0] sched_q, sched_d;
    logic [WIDTH-1:0] dout_d;
    logic             pending_d, cancel_d, ovf_d;

    // Inertial pending update.
    logic             ival_q, ival_d;
    logic [WIDTH-1:0] ivalue_q, ivalue_d;
    logic [CW-1:0]    icnt_q, icnt_d;

    // Transport event queue.
    logic [TW-1:0]    tnow_q, tnow_d;
    logic [WIDTH-1:0] fval_q [DEP];
    logic [TW-1:0]    fdue_q [DEP];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [NW-1:0]    fcnt_q, fcnt_d;

    logic change_c, push_c, pop_c, drop_c;

    // Next-state logic for both modes.
    always_comb begin
        sched_d   = sched_q;
        dout_d    = dout;
        cancel_d  = 1'b0;
        ovf_d     = ovf;
        ival_d    = ival_q;
        ivalue_d  = ivalue_q;
        icnt_d    = icnt_q;
        tnow_d    = tnow_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        fcnt_d    = fcnt_q;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        drop_c    = 1'b0;
        pending_d = 1'b0;

        change_c = (din != sched_q);
        if (change_c) begin
            sched_d = din;
        end

        if (!TRANSPORT) begin
            // A change always wins over an update maturing on the same edge,
            // and is judged against the pre-edge dout.
            if (change_c) begin
                cancel_d = ival_q;
                if (din != dout) begin
                    ival_d   = 1'b1;
                    ivalue_d = din;
                    icnt_d   = CW'(D);
                end else begin
                    ival_d = 1'b0;
                    icnt_d = '0;
                end
            end else if (ival_q) begin
                if (icnt_q == CW'(1)) begin
                    dout_d = ivalue_q;
                    ival_d = 1'b0;
                    icnt_d = '0;
                end else begin
                    icnt_d = icnt_q - CW'(1);
                end
            end
            pending_d = ival_d;
        end else begin
            tnow_d = tnow_q + TW'(1);
            pop_c  = (fcnt_q != '0) && (fdue_q[rd_ptr_q] == tnow_q);
            // A pop on the same edge frees a slot for a push to a full queue.
            push_c = change_c && ((fcnt_q != NW'(DEP)) || pop_c);
            drop_c = change_c && !push_c;
            if (pop_c) begin
                dout_d   = fval_q[rd_ptr_q];
                rd_ptr_d = (rd_ptr_q == PW'(DEP - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push_c) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEP - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            fcnt_d = fcnt_q + NW'(push_c) - NW'(pop_c);
            if (drop_c) begin
                ovf_d = 1'b1;
            end else if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            pending_d = (fcnt_d != '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched_q  <= RESET_VAL;
            dout     <= RESET_VAL;
            pending  <= 1'b0;
            cancel   <= 1'b0;
            ovf      <= 1'b0;
            ival_q   <= 1'b0;
            ivalue_q <= RESET_VAL;
            icnt_q   <= '0;
            tnow_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            sched_q  <= sched_d;
            dout     <= dout_d;
            pending  <= pending_d;
            cancel   <= cancel_d;
            ovf      <= ovf_d;
            ival_q   <= ival_d;
            ivalue_q <= ivalue_d;
            icnt_q   <= icnt_d;
            tnow_q   <= tnow_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Queue storage. Validity comes from fcnt_q, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fval_q[wr_ptr_q] <= din;
            fdue_q[wr_ptr_q] <= tnow_q + TW'(D);
        end
    end

endmodule

// File: tb/tb_cont_delay_line.sv
module tb_cont_delay_line;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] din_in, din_tr, din_ov;
    logic       clr_in, clr_tr, clr_ov;
    logic [3:0] dout_in, dout_tr, dout_ov;
    logic       pend_in, pend_tr, pend_ov;
    logic       canc_in, canc_tr, canc_ov;
    logic       ovf_in, ovf_tr, ovf_ov;

    // Inertial, D=2.
    cont_delay_line #(.WIDTH(4), .ASSIGN_DLY(1), .NET_DLY(1), .MODE(0), .DEPTH(4), .RESET_VAL(4'd0))
    u_in (.clk(clk), .rst_n(rst_n), .din(din_in), .clr_ovf(clr_in),
          .dout(dout_in), .pending(pend_in), .cancel(canc_in), .ovf(ovf_in));

    // Transport, D=2, DEPTH=4.
    cont_delay_line #(.WIDTH(4), .ASSIGN_DLY(1), .NET_DLY(1), .MODE(1), .DEPTH(4), .RESET_VAL(4'd0))
    u_tr (.clk(clk), .rst_n(rst_n), .din(din_tr), .clr_ovf(clr_tr),
          .dout(dout_tr), .pending(pend_tr), .cancel(canc_tr), .ovf(ovf_tr));

    // Transport, D=4, DEPTH=2.
    cont_delay_line #(.WIDTH(4), .ASSIGN_DLY(2), .NET_DLY(2), .MODE(1), .DEPTH(2), .RESET_VAL(4'd0))
    u_ov (.clk(clk), .rst_n(rst_n), .din(din_ov), .clr_ovf(clr_ov),
          .dout(dout_ov), .pending(pend_ov), .cancel(canc_ov), .ovf(ovf_ov));

    int total = 0;
    int bad   = 0;
    int k     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    // Reference model, with event times as absolute edge numbers.
    typedef struct {
        logic [3:0] v;
        int         due;
    } ev_t;

    logic [3:0] mi_sched, mi_dout, mi_pval;
    bit         mi_pend, mi_canc;
    int         mi_due;

    ev_t        tq [2][$];
    logic [3:0] mt_sched [2];
    logic [3:0] mt_dout  [2];
    bit         mt_ovf   [2];
    int         td   [2] = '{2, 4};
    int         tdep [2] = '{4, 2};

    task automatic model_reset();
        mi_sched = 4'd0; mi_dout = 4'd0; mi_pval = 4'd0;
        mi_pend = 1'b0; mi_canc = 1'b0; mi_due = 0;
        for (int i = 0; i < 2; i++) begin
            tq[i].delete();
            mt_sched[i] = 4'd0; mt_dout[i] = 4'd0; mt_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [3:0] dv;
        bit clr, drop;
        // Inertial: a change discards whatever is pending and schedules din
        // unless din is already on the net.
        mi_canc = 1'b0;
        if (din_in != mi_sched) begin
            mi_sched = din_in;
            if (mi_pend) mi_canc = 1'b1;
            if (din_in != mi_dout) begin
                mi_pend = 1'b1; mi_pval = din_in; mi_due = k + 2;
            end else begin
                mi_pend = 1'b0;
            end
        end else if (mi_pend && k == mi_due) begin
            mi_dout = mi_pval;
            mi_pend = 1'b0;
        end
        // Transport: every change is queued and replayed at its due edge.
        for (int i = 0; i < 2; i++) begin
            dv   = (i == 0) ? din_tr : din_ov;
            clr  = (i == 0) ? clr_tr : clr_ov;
            drop = 1'b0;
            if (tq[i].size() > 0 && tq[i][0].due == k) begin
                mt_dout[i] = tq[i][0].v;
                tq[i].delete(0);
            end
            if (dv != mt_sched[i]) begin
                mt_sched[i] = dv;
                if (tq[i].size() < tdep[i]) tq[i].push_back('{dv, k + td[i]});
                else drop = 1'b1;
            end
            if (drop) mt_ovf[i] = 1'b1;
            else if (clr) mt_ovf[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("in_dout",    32'(dout_in), 32'(mi_dout));
        chk("in_pending", 32'(pend_in), 32'(mi_pend));
        chk("in_cancel",  32'(canc_in), 32'(mi_canc));
        chk("in_ovf",     32'(ovf_in),  32'd0);
        chk("tr_dout",    32'(dout_tr), 32'(mt_dout[0]));
        chk("tr_pending", 32'(pend_tr), 32'(tq[0].size() > 0));
        chk("tr_cancel",  32'(canc_tr), 32'd0);
        chk("tr_ovf",     32'(ovf_tr),  32'(mt_ovf[0]));
        chk("ov_dout",    32'(dout_ov), 32'(mt_dout[1]));
        chk("ov_pending", 32'(pend_ov), 32'(tq[1].size() > 0));
        chk("ov_cancel",  32'(canc_ov), 32'd0);
        chk("ov_ovf",     32'(ovf_ov),  32'(mt_ovf[1]));
    endtask

    // One active edge: advance the model, then sample just after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        k++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_din(input logic [3:0] v);
        din_in = v; din_tr = v; din_ov = v;
    endtask

    typedef struct {
        bit         rst_before;
        logic [3:0] din;
        logic [3:0] in_dout;
        bit         in_pend;
        bit         in_canc;
        logic [3:0] tr_dout;
        bit         tr_pend;
    } vec_t;

    vec_t vt [$];

    initial begin
        // Hold, pulse reject and replace, each from reset. The transport
        // columns show the same stimulus replayed on u_tr.
        vt.push_back('{1, 4'd1, 4'd0, 1, 0, 4'd0, 1});
        vt.push_back('{0, 4'd1, 4'd0, 1, 0, 4'd0, 1});
        vt.push_back('{0, 4'd1, 4'd1, 0, 0, 4'd1, 0});
        vt.push_back('{0, 4'd1, 4'd1, 0, 0, 4'd1, 0});
        vt.push_back('{1, 4'd5, 4'd0, 1, 0, 4'd0, 1});
        vt.push_back('{0, 4'd0, 4'd0, 0, 1, 4'd0, 1});
        vt.push_back('{0, 4'd0, 4'd0, 0, 0, 4'd5, 1});
        vt.push_back('{0, 4'd0, 4'd0, 0, 0, 4'd0, 0});
        vt.push_back('{1, 4'd5, 4'd0, 1, 0, 4'd0, 1});
        vt.push_back('{0, 4'd7, 4'd0, 1, 1, 4'd0, 1});
        vt.push_back('{0, 4'd7, 4'd0, 1, 0, 4'd5, 1});
        vt.push_back('{0, 4'd7, 4'd7, 0, 0, 4'd7, 0});

        rst_n = 1'b0;
        set_din(4'd0);
        clr_in = 1'b0; clr_tr = 1'b0; clr_ov = 1'b0;
        model_reset();
        #1;
        chk("rst_dout",    32'(dout_in), 32'd0);
        chk("rst_pending", 32'(pend_in), 32'd0);
        chk("rst_cancel",  32'(canc_in), 32'd0);
        chk("rst_ovf",     32'(ovf_ov),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].rst_before) do_reset();
            set_din(vt[i].din);
            tick();
            chk("tbl_in_dout",    32'(dout_in), 32'(vt[i].in_dout));
            chk("tbl_in_pending", 32'(pend_in), 32'(vt[i].in_pend));
            chk("tbl_in_cancel",  32'(canc_in), 32'(vt[i].in_canc));
            chk("tbl_tr_dout",    32'(dout_tr), 32'(vt[i].tr_dout));
            chk("tbl_tr_pending", 32'(pend_tr), 32'(vt[i].tr_pend));
        end

        // Overflow on u_ov: D=4, DEPTH=2. The third event is dropped.
        do_reset();
        set_din(4'd1); tick();
        set_din(4'd2); tick();
        set_din(4'd3); tick();
        chk("ovf_set", 32'(ovf_ov), 32'd1);
        tick();
        chk("ovf_e3_dout", 32'(dout_ov), 32'd0);
        tick();
        chk("ovf_e4_dout", 32'(dout_ov), 32'd1);
        tick();
        chk("ovf_e5_dout", 32'(dout_ov), 32'd2);
        clr_ov = 1'b1; tick(); clr_ov = 1'b0;
        chk("ovf_clr", 32'(ovf_ov), 32'd0);
        chk("ovf_e6_dout", 32'(dout_ov), 32'd2);
        // A drop on the clearing edge keeps ovf set.
        set_din(4'd4); tick();
        set_din(4'd5); tick();
        set_din(4'd6); clr_ov = 1'b1; tick(); clr_ov = 1'b0;
        chk("ovf_drop_wins", 32'(ovf_ov), 32'd1);
        repeat (6) tick();

        // Reset asserted mid-operation discards the outstanding update.
        do_reset();
        set_din(4'd9); tick();
        chk("mid_pending_before", 32'(pend_in), 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_dout",    32'(dout_in), 32'd0);
        chk("mid_rst_pending", 32'(pend_in), 32'd0);
        chk("mid_rst_tr_pend", 32'(pend_tr), 32'd0);
        set_din(4'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_after_dout",    32'(dout_in), 32'd0);
            chk("mid_after_pending", 32'(pend_in), 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 1) == 0) din_in = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) din_tr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) din_ov = 4'($urandom_range(0, 15));
            clr_in = ($urandom_range(0, 5) == 0);
            clr_tr = ($urandom_range(0, 5) == 0);
            clr_ov = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
